// File: rtl/bnn_stream_feeder.sv
// rtl/bnn_stream_feeder.sv - on-chip source of binarised pixels, conv weight bits and FC weight words
module bnn_stream_feeder #(
  parameter int IMG_PIXELS = 784,
  parameter int THRESH     = 127,
  parameter int CONV1_BITS = 18,
  parameter int CONV2_BITS = 288,
  parameter int FC_DEPTH   = 800
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       rewind,
  input  logic       weight_en_0,
  input  logic       weight_en_1,
  input  logic       fc_ivalid,
  input  logic       ld_en,
  input  logic [1:0] ld_sel,
  input  logic [9:0] ld_addr,
  input  logic [9:0] ld_data,
  output logic       pic_dout,
  output logic       pic_valid,
  output logic       img_done,
  output logic       weight_conv_out,
  output logic [9:0] weight_fc_out,
  output logic       busy,
  output logic       ld_err
);

  localparam logic [9:0] IMG_LAST = 10'(IMG_PIXELS - 1);
  localparam logic [7:0] THR      = 8'(THRESH);
  localparam logic [4:0] C1_HALF  = 5'(CONV1_BITS / 2);
  localparam logic [4:0] C1_FULL  = 5'(CONV1_BITS);
  localparam logic [8:0] C2_LAST  = 9'(CONV2_BITS - 1);
  localparam logic [9:0] FC_LAST  = 10'(FC_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t state, state_nxt;
  logic   start_q;
  logic   emit;
  logic   addr_ok;
  logic   ld_wr;

  logic [9:0] img_ptr;
  logic [4:0] conv_cnt;
  logic [8:0] c2_ptr;
  logic [9:0] fc_ptr;

  logic [7:0]            img_mem [0:IMG_PIXELS-1];
  logic [9:0]            fc_mem  [0:FC_DEPTH-1];
  logic [CONV1_BITS-1:0] conv1_mem;
  logic [CONV2_BITS-1:0] conv2_mem;

  assign busy = (state == S_STREAM) || pic_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // The launch edge already emits pixel 0 so the first valid lands the cycle after start rises.
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    if (rewind) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !start_q) begin
            emit      = 1'b1;
            state_nxt = S_STREAM;
          end
        end
        S_STREAM: begin
          emit = 1'b1;
          if (img_ptr == IMG_LAST) state_nxt = S_DONE;
        end
        S_DONE: begin
          if (!start) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_q         <= 1'b0;
      img_ptr         <= '0;
      conv_cnt        <= '0;
      c2_ptr          <= '0;
      fc_ptr          <= '0;
      pic_dout        <= 1'b0;
      pic_valid       <= 1'b0;
      img_done        <= 1'b0;
      weight_conv_out <= 1'b0;
      weight_fc_out   <= '0;
    end else begin
      start_q <= start;
      if (rewind) begin
        img_ptr   <= '0;
        conv_cnt  <= '0;
        c2_ptr    <= '0;
        fc_ptr    <= '0;
        pic_valid <= 1'b0;
        img_done  <= 1'b0;
      end else begin
        pic_valid <= emit;
        img_done  <= (state == S_DONE) && pic_valid;
        if (emit) begin
          pic_dout <= (img_mem[img_ptr] > THR);
          img_ptr  <= (img_ptr == IMG_LAST) ? 10'd0 : img_ptr + 10'd1;
        end
        // conv1 first half belongs to group 0, second half to group 1; leftovers come from conv2
        if ((weight_en_0 && conv_cnt < C1_HALF) || (weight_en_1 && conv_cnt < C1_FULL)) begin
          weight_conv_out <= conv1_mem[conv_cnt];
          conv_cnt        <= conv_cnt + 5'd1;
        end else if (weight_en_0 || weight_en_1) begin
          weight_conv_out <= conv2_mem[c2_ptr];
          c2_ptr          <= (c2_ptr == C2_LAST) ? 9'd0 : c2_ptr + 9'd1;
        end
        if (fc_ivalid) begin
          weight_fc_out <= fc_mem[fc_ptr];
          fc_ptr        <= (fc_ptr == FC_LAST) ? 10'd0 : fc_ptr + 10'd1;
        end
      end
    end
  end

  always_comb begin
    addr_ok = 1'b0;
    case (ld_sel)
      2'd0:    addr_ok = ld_addr < 10'(IMG_PIXELS);
      2'd1:    addr_ok = ld_addr < 10'(CONV1_BITS);
      2'd2:    addr_ok = ld_addr < 10'(CONV2_BITS);
      default: addr_ok = ld_addr < 10'(FC_DEPTH);
    endcase
  end

  assign ld_wr = ld_en && !busy && addr_ok;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                       ld_err <= 1'b0;
    else if (ld_en && !ld_wr)        ld_err <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (ld_wr) begin
      case (ld_sel)
        2'd0:    img_mem[ld_addr]        <= ld_data[7:0];
        2'd1:    conv1_mem[ld_addr[4:0]] <= ld_data[0];
        2'd2:    conv2_mem[ld_addr[8:0]] <= ld_data[0];
        default: fc_mem[ld_addr]         <= ld_data;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_stream_feeder.sv
// tb/tb_bnn_stream_feeder.sv - randomized self-checking bench for bnn_stream_feeder
module tb_bnn_stream_feeder;

  localparam int NPIX = 784;
  localparam int NC1  = 18;
  localparam int NC2  = 288;
  localparam int NFC  = 800;

  logic       clk = 1'b0;
  logic       rstn, start, rewind, weight_en_0, weight_en_1, fc_ivalid, ld_en;
  logic [1:0] ld_sel;
  logic [9:0] ld_addr, ld_data;
  logic       pic_dout, pic_valid, img_done, weight_conv_out, busy, ld_err;
  logic [9:0] weight_fc_out;

  always #5 clk = ~clk;

  bnn_stream_feeder dut (
    .clk(clk), .rstn(rstn), .start(start), .rewind(rewind),
    .weight_en_0(weight_en_0), .weight_en_1(weight_en_1), .fc_ivalid(fc_ivalid),
    .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .pic_dout(pic_dout), .pic_valid(pic_valid), .img_done(img_done),
    .weight_conv_out(weight_conv_out), .weight_fc_out(weight_fc_out),
    .busy(busy), .ld_err(ld_err)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: memory images, a queue of pixel indices still owed, and served-bit counters.
  logic [7:0] m_img [NPIX];
  logic       m_c1  [NC1];
  logic       m_c2  [NC2];
  logic [9:0] m_fc  [NFC];
  int         pix_q [$];
  bit         done_pend, in_run, start_prev, prev_busy;
  int         c1_used, c2_idx, fc_idx;
  logic       e_valid, e_bit, e_done, e_conv, e_err;
  logic [9:0] e_fc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int depth(input logic [1:0] s);
    case (s)
      2'd0:    return NPIX;
      2'd1:    return NC1;
      2'd2:    return NC2;
      default: return NFC;
    endcase
  endfunction

  task automatic model_reset();
    pix_q.delete();
    done_pend = 0; in_run = 0; start_prev = 0; prev_busy = 0;
    c1_used = 0; c2_idx = 0; fc_idx = 0;
    e_valid = 0; e_bit = 0; e_done = 0; e_conv = 0; e_err = 0; e_fc = '0;
  endtask

  task automatic check_outputs();
    check_eq("pic_valid", pic_valid, e_valid);
    if (e_valid) check_eq("pic_dout", pic_dout, e_bit);
    check_eq("img_done", img_done, e_done);
    check_eq("busy", busy, e_valid);
    check_eq("conv_w", weight_conv_out, e_conv);
    check_eq("fc_w", weight_fc_out, e_fc);
    check_eq("ld_err", ld_err, e_err);
  endtask

  task automatic step();
    int idx;
    if (!rstn) begin
      model_reset();
    end else begin
      e_done = 1'b0;
      if (rewind) begin
        pix_q.delete();
        done_pend = 0; in_run = 0; e_valid = 0;
        c1_used = 0; c2_idx = 0; fc_idx = 0;
      end else begin
        e_done = done_pend;
        done_pend = 0;
        if (pix_q.size() > 0) begin
          idx = pix_q.pop_front();
          e_valid = 1; e_bit = (m_img[idx] > 127);
          if (pix_q.size() == 0) done_pend = 1;
        end else begin
          e_valid = 0;
          if (!in_run && start && !start_prev) begin
            for (int i = 1; i < NPIX; i++) pix_q.push_back(i);
            e_valid = 1; e_bit = (m_img[0] > 127); in_run = 1;
          end else if (in_run && !start) begin
            in_run = 0;
          end
        end
        if ((weight_en_0 && c1_used < NC1 / 2) || (weight_en_1 && c1_used < NC1)) begin
          e_conv = m_c1[c1_used]; c1_used++;
        end else if (weight_en_0 || weight_en_1) begin
          e_conv = m_c2[c2_idx]; c2_idx = (c2_idx + 1) % NC2;
        end
        if (fc_ivalid) begin
          e_fc = m_fc[fc_idx]; fc_idx = (fc_idx + 1) % NFC;
        end
      end
      start_prev = start;
      if (ld_en) begin
        if (prev_busy || int'(ld_addr) >= depth(ld_sel)) e_err = 1;
        else begin
          case (ld_sel)
            2'd0:    m_img[int'(ld_addr)] = ld_data[7:0];
            2'd1:    m_c1[int'(ld_addr)]  = ld_data[0];
            2'd2:    m_c2[int'(ld_addr)]  = ld_data[0];
            default: m_fc[int'(ld_addr)]  = ld_data;
          endcase
        end
      end
      prev_busy = e_valid;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic load(input logic [1:0] s, input int a, input int d);
    ld_en = 1; ld_sel = s; ld_addr = 10'(a); ld_data = 10'(d);
    step();
    ld_en = 0;
  endtask

  task automatic rand_req();
    weight_en_0 = ($urandom_range(0, 3) == 0);
    weight_en_1 = ($urandom_range(0, 3) == 0);
    fc_ivalid   = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_req();
    weight_en_0 = 0; weight_en_1 = 0; fc_ivalid = 0;
  endtask

  initial begin
    rstn = 0; start = 0; rewind = 0; ld_en = 0; ld_sel = '0; ld_addr = '0; ld_data = '0;
    clear_req();
    model_reset();
    repeat (3) step();
    rstn = 1;
    step();

    for (int i = 0; i < NPIX; i++) load(2'd0, i, i % 256);
    for (int i = 0; i < NC1; i++)  load(2'd1, i, i % 2);
    for (int i = 0; i < NC2; i++)  load(2'd2, i, int'($urandom_range(0, 1)));
    for (int i = 0; i < NFC; i++)  load(2'd3, i, i);
    load(2'd0, 784, 10'h3ff);
    load(2'd1, 18, 1);
    load(2'd3, 1023, 0);

    weight_en_0 = 1;
    repeat (9) step();
    weight_en_0 = 0; weight_en_1 = 1;
    repeat (12) step();
    weight_en_1 = 0;

    for (int j = 0; j < NFC + 1; j++) begin
      fc_ivalid = 1;
      step();
      fc_ivalid = 0;
      repeat ($urandom_range(0, 2)) step();
    end

    start = 1;
    repeat (NPIX + 12) begin rand_req(); step(); end
    clear_req();
    start = 0;
    repeat (2) step();

    for (int i = 0; i < NPIX; i++) load(2'd0, i, int'($urandom_range(0, 255)));
    load(2'd0, 0, 127);
    load(2'd0, 1, 128);
    load(2'd0, NPIX - 1, 128);

    start = 1;
    step();
    repeat (100) begin rand_req(); step(); end
    rewind = 1; weight_en_0 = 1; weight_en_1 = 0; fc_ivalid = 1;
    step();
    rewind = 0;
    clear_req();
    repeat (3) step();
    start = 0;
    step();

    start = 1;
    step();
    repeat (400) begin rand_req(); step(); end
    clear_req();
    #2;
    rstn = 0;
    #1;
    check_eq("rst_pic_valid", pic_valid, 1'b0);
    check_eq("rst_pic_dout", pic_dout, 1'b0);
    check_eq("rst_img_done", img_done, 1'b0);
    check_eq("rst_conv_w", weight_conv_out, 1'b0);
    check_eq("rst_fc_w", weight_fc_out, 10'd0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ld_err", ld_err, 1'b0);
    model_reset();
    start = 0;
    step();
    rstn = 1;
    step();

    start = 1;
    step();
    repeat (300) begin rand_req(); step(); end
    ld_en = 1; ld_sel = 2'd0; ld_addr = 10'd700; ld_data = {2'b00, ~m_img[700]};
    step();
    ld_en = 0;
    repeat (NPIX) begin rand_req(); step(); end
    clear_req();
    start = 0;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
